alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_core.sv | 94 +++++++++
 rtl/alu_pipe.sv | 98 +++++++++
 tb/tb_alu_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bundle and opcode legality helper.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SUBU = 5'b00011;
  localparam logic [4:0] OP_INC  = 5'b00100;
  localparam logic [4:0] OP_DEC  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b10001;
  localparam logic [4:0] OP_SLA  = 5'b10010;
  localparam logic [4:0] OP_SRA  = 5'b10011;
  localparam logic [4:0] OP_SLE  = 5'b11000;
  localparam logic [4:0] OP_SLT  = 5'b11001;
  localparam logic [4:0] OP_SGE  = 5'b11010;
  localparam logic [4:0] OP_SGT  = 5'b11011;
  localparam logic [4:0] OP_SEQ  = 5'b11100;
  localparam logic [4:0] OP_SNE  = 5'b11101;

  typedef struct packed {
    logic vout;
    logic cout;
    logic err;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SLL, OP_SRL, OP_SLA, OP_SRA,
      OP_SLE, OP_SLT, OP_SGE, OP_SGT, OP_SEQ, OP_SNE: is_legal_op = 1'b1;
      default:                                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; sits between the operand stage and the result stage.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       code_i,
  input  logic             coe_i,
  output logic [WIDTH-1:0] c_o,
  output logic             vout_o,
  output logic             cout_o,
  output logic             err_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] opb_w;
  logic [WIDTH-1:0] sll_w;
  logic [WIDTH-1:0] srl_w;
  logic [WIDTH-1:0] sra_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt_w;
  logic             incdec_w;
  logic             add_ovf_w;
  logic             sub_ovf_w;
  logic             lt_w;
  logic             eq_w;
  logic             cout_raw;

  // inc/dec reuse the add/sub paths with a constant one as second operand
  assign incdec_w = (code_i == OP_INC) || (code_i == OP_DEC);
  assign opb_w    = incdec_w ? {{(WIDTH-1){1'b0}}, 1'b1} : b_i;

  assign sum_w     = {1'b0, a_i} + {1'b0, opb_w};
  assign diff_w    = {1'b0, a_i} - {1'b0, opb_w};
  assign add_ovf_w = (a_i[MSB] == opb_w[MSB]) && (sum_w[MSB] != a_i[MSB]);
  assign sub_ovf_w = (a_i[MSB] != opb_w[MSB]) && (diff_w[MSB] != a_i[MSB]);

  assign shamt_w = b_i[SHW-1:0];
  assign sll_w   = a_i << shamt_w;
  assign srl_w   = a_i >> shamt_w;
  assign sra_w   = $signed(a_i) >>> shamt_w;

  assign lt_w = $signed(a_i) < $signed(b_i);
  assign eq_w = (a_i == b_i);

  always_comb begin
    c_o      = '0;
    vout_o   = 1'b0;
    cout_raw = 1'b0;
    case (code_i)
      OP_ADD, OP_INC: begin
        c_o      = sum_w[MSB:0];
        vout_o   = add_ovf_w;
        cout_raw = sum_w[WIDTH];
      end
      OP_ADDU: begin
        c_o      = sum_w[MSB:0];
        cout_raw = sum_w[WIDTH];
      end
      OP_SUB, OP_DEC: begin
        c_o      = diff_w[MSB:0];
        vout_o   = sub_ovf_w;
        cout_raw = diff_w[WIDTH];
      end
      OP_SUBU: begin
        c_o      = diff_w[MSB:0];
        cout_raw = diff_w[WIDTH];
      end
      OP_AND: c_o = a_i & b_i;
      OP_OR:  c_o = a_i | b_i;
      OP_XOR: c_o = a_i ^ b_i;
      OP_NOT: c_o = ~a_i;
      OP_SLL: c_o = sll_w;
      OP_SRL: c_o = srl_w;
      OP_SLA: c_o = {a_i[MSB], sll_w[MSB-1:0]};
      OP_SRA: c_o = sra_w;
      OP_SLE: c_o = {{(WIDTH-1){1'b0}}, lt_w | eq_w};
      OP_SLT: c_o = {{(WIDTH-1){1'b0}}, lt_w};
      OP_SGE: c_o = {{(WIDTH-1){1'b0}}, ~lt_w};
      OP_SGT: c_o = {{(WIDTH-1){1'b0}}, ~lt_w & ~eq_w};
      OP_SEQ: c_o = {{(WIDTH-1){1'b0}}, eq_w};
      OP_SNE: c_o = {{(WIDTH-1){1'b0}}, ~eq_w};
      default: ;
    endcase
  end

  // coe is an active-low enable for the carry/borrow flag only
  assign cout_o = cout_raw & ~coe_i;
  assign err_o  = ~is_legal_op(code_i);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 registers operands, S2 registers the result and flags.
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       alu_code,
  input  logic             coe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             vout,
  output logic             cout,
  output logic             err,
  output logic             ovf_sticky,
  input  logic             sticky_clr
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       code_q;
  logic             coe_q;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q;
  alu_flags_t       flags_q;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             s2_ready_w;
  logic [WIDTH-1:0] core_c;
  logic             core_vout, core_cout, core_err;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .code_i (code_q),
    .coe_i  (coe_q),
    .c_o    (core_c),
    .vout_o (core_vout),
    .cout_o (core_cout),
    .err_o  (core_err)
  );

  // Ready propagates backwards combinationally so a full pipe streams without bubbles
  assign s2_ready_w = ~out_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_ready_w;

  always_comb begin
    s1_valid_d   = in_ready   ? in_valid   : s1_valid_q;
    out_valid_d  = s2_ready_w ? s1_valid_q : out_valid_q;
    ovf_sticky_d = sticky_clr ? 1'b0
                 : (ovf_sticky_q | (out_valid_q & out_ready & flags_q.vout));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      code_q       <= '0;
      coe_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      c_q          <= '0;
      flags_q      <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      ovf_sticky_q <= ovf_sticky_d;
      if (in_ready && in_valid) begin
        a_q    <= A;
        b_q    <= B;
        code_q <= alu_code;
        coe_q  <= coe;
      end
      if (s2_ready_w && s1_valid_q) begin
        c_q     <= core_c;
        flags_q <= '{vout: core_vout, cout: core_cout, err: core_err};
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign C          = c_q;
  assign vout       = flags_q.vout;
  assign cout       = flags_q.cout;
  assign err        = flags_q.err;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16): directed vectors, stall, reset and random traffic.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] c;
    logic        v;
    logic        co;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] A, B;
  logic [4:0]  alu_code;
  logic        coe;
  logic        out_valid, out_ready;
  logic [15:0] C;
  logic        vout, cout, err;
  logic        ovf_sticky, sticky_clr;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t held;
  logic stalled  = 1'b0;
  logic sticky_m = 1'b0;
  logic mon_en   = 1'b0;
  logic rand_mode = 1'b0;
  logic hs_v;

  alu_pipe #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .alu_code   (alu_code),
    .coe        (coe),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .C          (C),
    .vout       (vout),
    .cout       (cout),
    .err        (err),
    .ovf_sticky (ovf_sticky),
    .sticky_clr (sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] c, input logic v, input logic co, input logic e);
    exp_t r;
    r.c = c; r.v = v; r.co = co; r.err = e;
    return r;
  endfunction

  // Reference model in plain integer arithmetic
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] op, input logic cx);
    exp_t e;
    int ua, ub, sa, sb, r, n;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); n = b[3:0];
    e = '0;
    case (op)
      OP_ADD:  begin r = sa + sb; e.v = (r > 32767) || (r < -32768);
                     e.co = (ua + ub) > 65535; e.c = 16'(ua + ub); end
      OP_ADDU: begin e.co = (ua + ub) > 65535; e.c = 16'(ua + ub); end
      OP_SUB:  begin r = sa - sb; e.v = (r > 32767) || (r < -32768);
                     e.co = ua < ub; e.c = 16'(ua - ub); end
      OP_SUBU: begin e.co = ua < ub; e.c = 16'(ua - ub); end
      OP_INC:  begin e.v = (sa + 1) > 32767; e.co = (ua + 1) > 65535; e.c = 16'(ua + 1); end
      OP_DEC:  begin e.v = (sa - 1) < -32768; e.co = ua < 1; e.c = 16'(ua - 1); end
      OP_AND:  e.c = a & b;
      OP_OR:   e.c = a | b;
      OP_XOR:  e.c = a ^ b;
      OP_NOT:  e.c = ~a;
      OP_SLL:  e.c = 16'(ua << n);
      OP_SRL:  e.c = 16'(ua >> n);
      OP_SLA:  begin e.c = 16'(ua << n); e.c[15] = a[15]; end
      OP_SRA:  e.c = 16'(sa >>> n);
      OP_SLE:  e.c = (sa <= sb) ? 16'd1 : 16'd0;
      OP_SLT:  e.c = (sa <  sb) ? 16'd1 : 16'd0;
      OP_SGE:  e.c = (sa >= sb) ? 16'd1 : 16'd0;
      OP_SGT:  e.c = (sa >  sb) ? 16'd1 : 16'd0;
      OP_SEQ:  e.c = (sa == sb) ? 16'd1 : 16'd0;
      OP_SNE:  e.c = (sa != sb) ? 16'd1 : 16'd0;
      default: e.err = 1'b1;
    endcase
    if (cx) e.co = 1'b0;
    return e;
  endfunction

  // Offer one op, wait for acceptance (bounded), push its expected result.
  task automatic issue_core(input logic [15:0] a, input logic [15:0] b,
                            input logic [4:0] op, input logic cx, input exp_t e);
    int n;
    n = 0;
    A = a; B = b; alu_code = op; coe = cx; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        in_valid = 1'b0;
        return;
      end
    end
    sb_q.push_back(e);
    $display("issue op=%b A=%h B=%h coe=%b exp C=%h v=%b co=%b err=%b",
             op, a, b, cx, e.c, e.v, e.co, e.err);
    @(posedge clk); #1;
  endtask

  task automatic issue_m(input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] op, input logic cx);
    issue_core(a, b, op, cx, model(a, b, op, cx));
  endtask

  task automatic issue_e(input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] op, input logic cx, input exp_t e);
    issue_core(a, b, op, cx, e);
  endtask

  task automatic idle(input int cyc);
    in_valid = 1'b0;
    repeat (cyc) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("drain_empty", sb_q.size(), 0);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 6))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  // Monitor: compares each delivered result, checks stall stability and the sticky flag.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, sticky_m});
      if (stalled) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_C", {16'b0, C}, {16'b0, held.c});
        check("stall_flags", {29'b0, vout, cout, err}, {29'b0, held.v, held.co, held.err});
      end
      hs_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got C=%h with empty scoreboard expected none", C);
        end else begin
          mon_e = sb_q.pop_front();
          hs_v  = mon_e.v;
          $display("result C=%h v=%b co=%b err=%b exp C=%h v=%b co=%b err=%b",
                   C, vout, cout, err, mon_e.c, mon_e.v, mon_e.co, mon_e.err);
          check("C", {16'b0, C}, {16'b0, mon_e.c});
          check("vout", {31'b0, vout}, {31'b0, mon_e.v});
          check("cout", {31'b0, cout}, {31'b0, mon_e.co});
          check("err", {31'b0, err}, {31'b0, mon_e.err});
        end
      end
      stalled = out_valid && !out_ready;
      held    = mk(C, vout, cout, err);
      if (sticky_clr)  sticky_m = 1'b0;
      else if (hs_v)   sticky_m = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready  = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  logic [4:0] legal_ops [20];

  initial begin
    legal_ops = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_INC, OP_DEC, OP_AND, OP_OR,
                  OP_XOR, OP_NOT, OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_SLE, OP_SLT,
                  OP_SGE, OP_SGT, OP_SEQ, OP_SNE};
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; alu_code = '0; coe = 1'b0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_C", {16'b0, C}, 32'd0);
    check("rst_flags", {28'b0, vout, cout, err, ovf_sticky}, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Overflow, latency and sticky flag
    issue_e(16'h7FFF, 16'h0001, OP_ADD, 1'b0, mk(16'h8000, 1'b1, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_cycle2", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    check("sticky_set", {31'b0, ovf_sticky}, 32'd1);
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", {31'b0, ovf_sticky}, 32'd0);
    @(posedge clk); #1;

    // Arithmetic, shift, compare and illegal-opcode vectors, back to back
    issue_e(16'hA00A, 16'h1004, OP_ADD,  1'b0, mk(16'hB00E, 1'b0, 1'b0, 1'b0));
    issue_e(16'hA00A, 16'h1004, OP_SUBU, 1'b0, mk(16'h9006, 1'b0, 1'b0, 1'b0));
    issue_e(16'h1004, 16'hA00A, OP_SUBU, 1'b0, mk(16'h6FFA, 1'b0, 1'b1, 1'b0));
    issue_e(16'h1004, 16'hA00A, OP_SUBU, 1'b1, mk(16'h6FFA, 1'b0, 1'b0, 1'b0));
    issue_e(16'h8012, 16'h0004, OP_SRA,  1'b0, mk(16'hF801, 1'b0, 1'b0, 1'b0));
    issue_e(16'hF14A, 16'h0002, OP_SLA,  1'b0, mk(16'hC528, 1'b0, 1'b0, 1'b0));
    issue_e(16'h8012, 16'h0004, OP_SRL,  1'b0, mk(16'h0801, 1'b0, 1'b0, 1'b0));
    issue_e(16'hF14A, 16'hF002, OP_SLT,  1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0));
    issue_e(16'hF14A, 16'hF002, OP_SGT,  1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0));
    issue_e(16'hF14A, 16'hF002, OP_SNE,  1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0));
    issue_e(16'hF14A, 16'hF002, OP_SEQ,  1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0));
    issue_e(16'hF14A, 16'hF002, 5'b00110, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1));
    issue_e(16'h0000, 16'h0000, OP_DEC,  1'b0, mk(16'hFFFF, 1'b0, 1'b1, 1'b0));
    issue_e(16'h8000, 16'h0000, OP_DEC,  1'b0, mk(16'h7FFF, 1'b1, 1'b0, 1'b0));
    idle(4);

    // Backpressure: only two ops fit while the output is stalled
    out_ready = 1'b0;
    issue_m(16'h1111, 16'h2222, OP_ADD, 1'b0);
    issue_m(16'h8000, 16'h0001, OP_SUB, 1'b0);
    A = 16'h00F0; B = 16'h0003; alu_code = OP_SLL; coe = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue_m(16'h00F0, 16'h0003, OP_SLL, 1'b0);
    issue_m(16'hFFFF, 16'h0001, OP_ADDU, 1'b0);
    drain();

    // Random traffic with random backpressure and sticky clears
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else if ($urandom_range(0, 9) == 0)
        issue_m(rnd16(), rnd16(), 5'($urandom()), 1'($urandom()));
      else
        issue_m(rnd16(), rnd16(), legal_ops[$urandom_range(0, 19)], 1'($urandom()));
    end
    in_valid = 1'b0;
    rand_mode = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1; sticky_clr = 1'b0;
    drain();

    // Reset with operations in flight
    issue_m(16'h7FFF, 16'h7FFF, OP_ADD, 1'b0);
    issue_m(16'h1234, 16'h4321, OP_XOR, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_sticky", {31'b0, ovf_sticky}, 32'd0);
    check("rst_mid_C", {16'b0, C}, 32'd0);
    sb_q.delete();
    sticky_m = 1'b0;
    stalled  = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_result", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue_m(16'h0005, 16'h0003, OP_SUB, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
